// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: iterative restoring divider, 2W/W -> W quotient and W remainder, one bit per clock (DIV_SIGNED_EN selects two's-complement operands)
module seq_restoring_divider #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               div_by_zero,
    output logic               overflow
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t             state, state_nx;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     rem;
    logic [WIDTH-1:0]   lo, dv, d_mag, q_fin, r_fin;
    logic [2*WIDTH-1:0] n_mag;
    logic [WIDTH+1:0]   shifted, diff;
    logic               n_neg, d_neg, neg_q, neg_r, accept, dz, ov_pre, err, ov_fin;
`ifdef DIV_SIGNED_EN
    assign n_neg  = dividend[2*WIDTH-1];
    assign d_neg  = divisor[WIDTH-1];
    assign ov_fin = neg_q ? (lo > {1'b1, {(WIDTH-1){1'b0}}}) : lo[WIDTH-1];
`else
    assign n_neg  = 1'b0;
    assign d_neg  = 1'b0;
    assign ov_fin = 1'b0;
`endif
    assign n_mag   = n_neg ? -dividend : dividend;
    assign d_mag   = d_neg ? -divisor : divisor;
    assign dz      = (divisor == '0);
    assign ov_pre  = (n_mag[2*WIDTH-1:WIDTH] >= d_mag) && !dz;
    assign err     = dz || ov_pre;
    assign accept  = start && (state == IDLE || state == DONE);
    assign shifted = {rem, lo[WIDTH-1]};
    assign diff    = shifted - {2'b00, dv};
    assign q_fin   = neg_q ? -lo : lo;
    assign r_fin   = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
    assign busy    = (state == RUN) && (cnt != '0);
    assign done    = (state == DONE);
    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    // next state: errors bypass RUN, RUN ends one cycle after the last quotient bit
    always_comb begin
        state_nx = accept ? (err ? DONE : RUN) :
                   (state == DONE) ? IDLE :
                   (state == RUN && cnt == '0) ? DONE : state;
    end
    // operand capture, shift/trial-subtract iteration, result registration into DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            rem         <= '0;
            lo          <= '0;
            dv          <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else if (accept) begin
            cnt         <= CW'(WIDTH);
            rem         <= {1'b0, n_mag[2*WIDTH-1:WIDTH]};
            lo          <= n_mag[WIDTH-1:0];
            dv          <= d_mag;
            neg_q       <= n_neg ^ d_neg;
            neg_r       <= n_neg;
            div_by_zero <= dz;
            overflow    <= ov_pre;
            if (err) begin
                quotient  <= '1;
                remainder <= dividend[WIDTH-1:0];
            end
        end else if (state == RUN) begin
            if (cnt != '0) begin
                rem <= diff[WIDTH+1] ? shifted[WIDTH:0] : diff[WIDTH:0];
                lo  <= {lo[WIDTH-2:0], ~diff[WIDTH+1]};
                cnt <= cnt - CW'(1);
            end else begin
                quotient  <= q_fin;
                remainder <= r_fin;
                overflow  <= ov_fin;
            end
        end
    end
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: randomized self-checking bench against a plain-arithmetic division model
module tb_seq_restoring_divider;
    logic        clk = 1'b0;
    logic        rst, start;
    logic [63:0] dividend;
    logic [31:0] divisor;
    logic        busy, done, div_by_zero, overflow;
    logic [31:0] quotient, remainder;
    int          checks = 0;
    int          passes = 0;

    seq_restoring_divider #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // expected {quotient, remainder, div_by_zero, overflow} for unsigned operands
    function automatic logic [65:0] model(input logic [63:0] n, input logic [31:0] d);
        logic [63:0] hi;
        hi = n >> 32;
        if (d == 0) return {32'hFFFFFFFF, n[31:0], 2'b10};
        if (hi >= {32'd0, d}) return {32'hFFFFFFFF, n[31:0], 2'b01};
        return {32'(n / {32'd0, d}), 32'(n % {32'd0, d}), 2'b00};
    endfunction

    function automatic int model_lat(input logic [63:0] n, input logic [31:0] d);
        logic [63:0] hi;
        hi = n >> 32;
        return (d == 0 || hi >= {32'd0, d}) ? 0 : 33;
    endfunction

    task automatic start_op(input logic [63:0] n, input logic [31:0] d);
        @(negedge clk);
        start = 1'b1; dividend = n; divisor = d;
        @(posedge clk);
        #1 start = 1'b0; dividend = {$urandom, $urandom}; divisor = $urandom;
    endtask

    // lat = cycles after the start edge until done is seen; -1 if never
    task automatic wait_done(output int lat, output int bc);
        lat = -1; bc = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (busy) bc++;
            if (done) begin lat = k; break; end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero, overflow} !== 68'd0)
            $display("FAIL reset: outputs=%h required 0", {busy, done, quotient, remainder, div_by_zero, overflow});
        else passes++;
    endtask

    task automatic test_exact;
        int lat, bc;
        logic [63:0] n;
        n = 64'h00000000AAAAAAAA * 64'h0000000055555555;
        start_op(n, 32'h55555555);
        wait_done(lat, bc);
        checks++;
        if ({quotient, remainder, div_by_zero, overflow} !== {32'hAAAAAAAA, 32'h0, 2'b00})
            $display("FAIL exact: got q=%h r=%h dz=%b ov=%b required q=aaaaaaaa r=0", quotient, remainder, div_by_zero, overflow);
        else passes++;
        checks++;
        if (lat !== 33) $display("FAIL exact_latency: got %0d required 33", lat); else passes++;
        checks++;
        if (bc !== 32) $display("FAIL exact_busy_cycles: got %0d required 32", bc); else passes++;
        @(negedge clk);
        checks++;
        if (done !== 1'b0) $display("FAIL done_pulse_width: done=%b required 0", done); else passes++;
    endtask

    task automatic test_remainder;
        int lat, bc;
        start_op(64'h0000000000010007, 32'h00000100);
        wait_done(lat, bc);
        checks++;
        if ({quotient, remainder, div_by_zero, overflow} !== {32'h100, 32'h7, 2'b00})
            $display("FAIL remainder: got q=%h r=%h dz=%b ov=%b required q=100 r=7 dz=0 ov=0", quotient, remainder, div_by_zero, overflow);
        else passes++;
    endtask

    task automatic test_div_zero;
        int lat, bc;
        start_op(64'h00000000FFFF1234, 32'h0);
        wait_done(lat, bc);
        checks++;
        if ({quotient, remainder, div_by_zero, overflow, lat, bc} !== {32'hFFFFFFFF, 32'hFFFF1234, 2'b10, 32'd0, 32'd0})
            $display("FAIL div_zero: got q=%h r=%h dz=%b ov=%b lat=%0d busy=%0d required q=ffffffff r=ffff1234 dz=1 ov=0 lat=0 busy=0",
                     quotient, remainder, div_by_zero, overflow, lat, bc);
        else passes++;
    endtask

    task automatic test_overflow;
        int lat, bc;
        start_op(64'h0000000100000000, 32'h1);
        wait_done(lat, bc);
        checks++;
        if ({quotient, remainder, div_by_zero, overflow, lat, bc} !== {32'hFFFFFFFF, 32'h0, 2'b01, 32'd0, 32'd0})
            $display("FAIL overflow: got q=%h r=%h dz=%b ov=%b lat=%0d busy=%0d required q=ffffffff r=0 dz=0 ov=1 lat=0 busy=0",
                     quotient, remainder, div_by_zero, overflow, lat, bc);
        else passes++;
    endtask

    task automatic test_random;
        int lat, bc;
        logic [63:0] n;
        logic [31:0] d;
        for (int i = 0; i < 12; i++) begin
            if (i % 6 == 4) begin
                d = 32'($urandom_range(1, 1000));
                n = {32'($urandom_range(1000, 32'hFFFF)), 32'($urandom)};
            end else if (i % 6 == 5) begin
                d = 32'h0;
                n = {$urandom, $urandom};
            end else begin
                d = $urandom | 32'h1;
                n = {$urandom % d, $urandom};
            end
            start_op(n, d);
            wait_done(lat, bc);
            checks++;
            if ({quotient, remainder, div_by_zero, overflow} !== model(n, d))
                $display("FAIL random_%0d: n=%h d=%h got %h required %h", i, n, d,
                         {quotient, remainder, div_by_zero, overflow}, model(n, d));
            else passes++;
            checks++;
            if (lat !== model_lat(n, d)) $display("FAIL random_lat_%0d: got %0d required %0d", i, lat, model_lat(n, d));
            else passes++;
        end
    endtask

    task automatic test_ignore_start;
        int lat, bc, extra;
        logic [63:0] n;
        logic [31:0] d;
        d = $urandom | 32'h1;
        n = {$urandom % d, $urandom};
        start_op(n, d);
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1; dividend = 64'h0000000000000009; divisor = 32'h3;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, bc);
        checks++;
        if ({quotient, remainder, div_by_zero, overflow} !== model(n, d))
            $display("FAIL ignore_start: got %h required %h", {quotient, remainder, div_by_zero, overflow}, model(n, d));
        else passes++;
        checks++;
        if (lat !== 28) $display("FAIL ignore_start_lat: got %0d required 28", lat); else passes++;
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (busy || done) extra++;
        end
        checks++;
        if (extra !== 0) $display("FAIL ignore_start_queued: busy/done cycles=%0d required 0", extra); else passes++;
    endtask

    task automatic test_back_to_back;
        int lat, bc;
        logic [63:0] n1, n2;
        logic [31:0] d1, d2;
        d1 = $urandom | 32'h1; n1 = {$urandom % d1, $urandom};
        d2 = $urandom | 32'h1; n2 = {$urandom % d2, $urandom};
        start_op(n1, d1);
        wait_done(lat, bc);
        checks++;
        if ({quotient, remainder, div_by_zero, overflow} !== model(n1, d1))
            $display("FAIL b2b_first: got %h required %h", {quotient, remainder, div_by_zero, overflow}, model(n1, d1));
        else passes++;
        start = 1'b1; dividend = n2; divisor = d2;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, bc);
        checks++;
        if ({quotient, remainder, div_by_zero, overflow} !== model(n2, d2))
            $display("FAIL b2b_second: got %h required %h", {quotient, remainder, div_by_zero, overflow}, model(n2, d2));
        else passes++;
        checks++;
        if (lat !== 33) $display("FAIL b2b_latency: got %0d required 33", lat); else passes++;
    endtask

    task automatic test_reset_abort;
        int dones;
        logic [31:0] d;
        d = $urandom | 32'h1;
        start_op({$urandom % d, $urandom}, d);
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero, overflow} !== 68'd0)
            $display("FAIL reset_abort: outputs=%h required 0", {busy, done, quotient, remainder, div_by_zero, overflow});
        else passes++;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        checks++;
        if (dones !== 0) $display("FAIL reset_abort_done: busy/done cycles=%0d required 0", dones); else passes++;
    endtask

`ifdef DIV_SIGNED_EN
    task automatic test_signed;
        int lat, bc;
        start_op(64'hFFFFFFFFFFFFFFF9, 32'h2);
        wait_done(lat, bc);
        checks++;
        if ({quotient, remainder, div_by_zero, overflow} !== {32'hFFFFFFFD, 32'hFFFFFFFF, 2'b00})
            $display("FAIL signed: got q=%h r=%h dz=%b ov=%b required q=fffffffd r=ffffffff", quotient, remainder, div_by_zero, overflow);
        else passes++;
        checks++;
        if (lat !== 33) $display("FAIL signed_latency: got %0d required 33", lat); else passes++;
    endtask
`endif

    initial begin
        test_reset;
`ifdef DIV_SIGNED_EN
        test_signed;
`else
        test_exact;
        test_remainder;
        test_div_zero;
        test_overflow;
        test_random;
        test_ignore_start;
        test_back_to_back;
        test_reset_abort;
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
